// File: rtl/regfile_bank.sv
// regfile_bank: multi-entry register file with byte-enabled write port, two combinational
// read ports, optional write-to-read bypass, optional hardwired-zero entry 0, and a
// bulk-clear engine that sweeps one entry per cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   we       in   write request
//   waddr    in   write address
//   wdata    in   write data
//   wbe      in   byte enables, bit i covers wdata[8i+7:8i]
//   wr_ack   out  combinational write-accept
//   raddr_a  in   read address, port A
//   rdata_a  out  read data, port A (combinational)
//   raddr_b  in   read address, port B
//   rdata_b  out  read data, port B (combinational)
//   clr_req  in   pulse that starts a bulk clear
//   busy     out  high while the bulk clear sweeps
module regfile_bank #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter bit          BYPASS    = 1'b1,
    parameter bit          ZERO_REG0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wbe,
    output logic                 wr_ack,
    input  logic [ADDR_W-1:0]    raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [WIDTH-1:0]     rdata_b,
    input  logic                 clr_req,
    output logic                 busy
);

    localparam int unsigned NB   = WIDTH / 8;
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0]   DepthA  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic waddr_ok;

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_v,
                                                      input logic [WIDTH-1:0] new_v,
                                                      input logic [NB-1:0]    be);
        logic [WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign busy     = (state_q == StSweep);
    assign waddr_ok = ({1'b0, waddr} < DepthA) && !(ZERO_REG0 && (waddr == '0));
    assign wr_ack   = we & ~busy & waddr_ok;

    // Next-state: writes only land in IDLE; the sweep owns the array while busy.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        unique case (state_q)
            StIdle: begin
                if (wr_ack) begin
                    mem_d[waddr[IdxW-1:0]] = merge_bytes(mem_q[waddr[IdxW-1:0]], wdata, wbe);
                end
                // A write accepted on the same edge is wiped later by the sweep.
                if (clr_req) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                end
            end
            StSweep: begin
                mem_d[ptr_q] = '0;
                if (ptr_q == LastIdx) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mem_q   <= mem_d;
        end
    end

    // Read ports: out-of-range and hardwired-zero addresses read 0; bypass merges the
    // in-flight accepted write over the stored bytes.
    always_comb begin
        rdata_a = '0;
        if (({1'b0, raddr_a} < DepthA) && !(ZERO_REG0 && (raddr_a == '0))) begin
            rdata_a = mem_q[raddr_a[IdxW-1:0]];
            if (BYPASS && wr_ack && (raddr_a == waddr)) begin
                rdata_a = merge_bytes(mem_q[raddr_a[IdxW-1:0]], wdata, wbe);
            end
        end
    end

    always_comb begin
        rdata_b = '0;
        if (({1'b0, raddr_b} < DepthA) && !(ZERO_REG0 && (raddr_b == '0))) begin
            rdata_b = mem_q[raddr_b[IdxW-1:0]];
            if (BYPASS && wr_ack && (raddr_b == waddr)) begin
                rdata_b = merge_bytes(mem_q[raddr_b[IdxW-1:0]], wdata, wbe);
            end
        end
    end

endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [5:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        wr_ack;
    logic [5:0]  raddr_a = '0;
    logic [31:0] rdata_a;
    logic [5:0]  raddr_b = '0;
    logic [31:0] rdata_b;
    logic        clr_req = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    regfile_bank #(
        .WIDTH(32), .DEPTH(32), .ADDR_W(6), .BYPASS(1'b1), .ZERO_REG0(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .wr_ack(wr_ack), .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b),
        .rdata_b(rdata_b), .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: array of entry values plus the number of sweep cycles remaining.
    logic [31:0] m_mem [32];
    int          sweep_left = 0;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic m_ack();
        return we && (sweep_left == 0) && (int'(waddr) < 32) && (waddr != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        logic [31:0] v;
        if (int'(a) >= 32 || a == 0) return 32'h0;
        v = m_mem[a[4:0]];
        if (m_ack() && a == waddr) v = (v & ~be_mask(wbe)) | (wdata & be_mask(wbe));
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        sweep_left = 0;
    endtask

    task automatic model_edge();
        if (sweep_left > 0) begin
            m_mem[32 - sweep_left] = '0;
            sweep_left--;
        end else begin
            if (m_ack()) begin
                m_mem[waddr[4:0]] = (m_mem[waddr[4:0]] & ~be_mask(wbe)) | (wdata & be_mask(wbe));
            end
            if (clr_req) sweep_left = 32;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [5:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic [5:0] ra, input logic [5:0] rb,
                         input logic clr);
        we = w; waddr = wa; wdata = wd; wbe = be; raddr_a = ra; raddr_b = rb; clr_req = clr;
    endtask

    task automatic model_check();
        chk("m_wr_ack", {31'b0, wr_ack}, {31'b0, m_ack()});
        chk("m_rdata_a", rdata_a, m_read(raddr_a));
        chk("m_rdata_b", rdata_b, m_read(raddr_b));
        chk("m_busy", {31'b0, busy}, {31'b0, (sweep_left > 0)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [5:0]  ra;
        logic [5:0]  rb;
        logic        ack;
        logic [31:0] xa;
        logic [31:0] xb;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [5:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic [5:0] ra,
                                input logic [5:0] rb, input logic ack,
                                input logic [31:0] xa, input logic [31:0] xb);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.be = be; v.ra = ra; v.rb = rb;
        v.ack = ack; v.xa = xa; v.xb = xb;
        return v;
    endfunction

    vec_t vecs [11];
    int   busy_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        vecs[0]  = mk(1, 3,  32'h11223344, 4'hF, 3,  3, 1, 32'h11223344, 32'h11223344);
        vecs[1]  = mk(1, 3,  32'hAABBCCDD, 4'h5, 3,  4, 1, 32'h11BB33DD, 32'h0);
        vecs[2]  = mk(0, 0,  32'h0,        4'h0, 3,  0, 0, 32'h11BB33DD, 32'h0);
        vecs[3]  = mk(1, 7,  32'h12345678, 4'h3, 7,  7, 1, 32'h00005678, 32'h00005678);
        vecs[4]  = mk(0, 0,  32'h0,        4'h0, 7,  3, 0, 32'h00005678, 32'h11BB33DD);
        vecs[5]  = mk(1, 0,  32'hFFFFFFFF, 4'hF, 0,  3, 0, 32'h0,        32'h11BB33DD);
        vecs[6]  = mk(1, 40, 32'hFFFFFFFF, 4'hF, 40, 8, 0, 32'h0,        32'h0);
        vecs[7]  = mk(0, 0,  32'h0,        4'h0, 8,  0, 0, 32'h0,        32'h0);
        vecs[8]  = mk(1, 5,  32'hDEADBEEF, 4'hF, 5,  3, 1, 32'hDEADBEEF, 32'h11BB33DD);
        vecs[9]  = mk(1, 9,  32'hFFFFFFFF, 4'h0, 9,  9, 1, 32'h0,        32'h0);
        vecs[10] = mk(0, 0,  32'h0,        4'h0, 9,  5, 0, 32'h0,        32'hDEADBEEF);

        // Power-on reset, released between edges.
        #12 rst = 1'b1;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 5, 31, 0);
        #1;
        chk("reset_rdata_a", rdata_a, 32'h0);
        chk("reset_rdata_b", rdata_b, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_wr_ack", {31'b0, wr_ack}, 32'h0);
        tick();

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].ra, vecs[i].rb, 0);
            #1;
            chk($sformatf("vec%0d_wr_ack", i), {31'b0, wr_ack}, {31'b0, vecs[i].ack});
            chk($sformatf("vec%0d_rdata_a", i), rdata_a, vecs[i].xa);
            chk($sformatf("vec%0d_rdata_b", i), rdata_b, vecs[i].xb);
            tick();
        end

        // Asynchronous reset mid-cycle clears entry 5 with no clock edge.
        drive(0, 0, 0, 0, 5, 3, 0);
        #1;
        chk("pre_async_rdata_a", rdata_a, 32'hDEADBEEF);
        rst = 1'b0;
        #1;
        chk("async_rst_rdata_a", rdata_a, 32'h0);
        chk("async_rst_rdata_b", rdata_b, 32'h0);
        chk("async_rst_busy", {31'b0, busy}, 32'h0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        tick();

        // Fill entries with their index, then sweep.
        for (int i = 1; i < 32; i++) begin
            drive(1, 6'(i), 32'(i), 4'hF, 6'(i), 6'(i - 1), 0);
            #1;
            model_check();
            tick();
        end
        drive(0, 0, 0, 0, 31, 1, 1);
        #1;
        model_check();
        tick();
        busy_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            if (k == 10) begin
                drive(1, 12, 32'hCAFEF00D, 4'hF, 9, 10, 0);
            end else if (k == 12) begin
                drive(0, 0, 0, 0, 31, 11, 1);
            end else if (k < 32) begin
                drive(0, 0, 0, 0, 6'(k), 6'(k == 0 ? 0 : k - 1), 0);
            end else begin
                drive(0, 0, 0, 0, 6'((k - 32) * 2), 6'((k - 32) * 2 + 1), 0);
            end
            #1;
            model_check();
            if (busy) busy_cnt++;
            if (k == 10) begin
                chk("sweep10_wr_ack", {31'b0, wr_ack}, 32'h0);
                chk("sweep10_entry9", rdata_a, 32'h0);
                chk("sweep10_entry10", rdata_b, 32'd10);
            end
            if (k >= 32) begin
                chk("post_sweep_a", rdata_a, 32'h0);
                chk("post_sweep_b", rdata_b, 32'h0);
            end
            tick();
        end
        chk("sweep_busy_cycles", 32'(busy_cnt), 32'd32);

        // Reset in the middle of a sweep.
        for (int i = 25; i < 32; i++) begin
            drive(1, 6'(i), 32'hA5A50000 | 32'(i), 4'hF, 0, 0, 0);
            #1;
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 6'(k), 31, 0);
            #1;
            model_check();
            tick();
        end
        drive(0, 0, 0, 0, 20, 31, 0);
        rst = 1'b0;
        #1;
        chk("midsweep_rst_busy", {31'b0, busy}, 32'h0);
        chk("midsweep_rst_entry31", rdata_b, 32'h0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        tick();
        drive(1, 20, 32'h0BADF00D, 4'hF, 0, 0, 0);
        #1;
        chk("after_rst_wr_ack", {31'b0, wr_ack}, 32'h1);
        tick();
        drive(0, 0, 0, 0, 20, 20, 0);
        #1;
        chk("after_rst_read_a", rdata_a, 32'h0BADF00D);
        chk("after_rst_read_b", rdata_b, 32'h0BADF00D);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 45)), $urandom,
                  4'($urandom), 6'($urandom_range(0, 40)), 6'($urandom_range(0, 40)),
                  1'($urandom_range(0, 59) == 0));
            #1;
            model_check();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised multi-entry register file built from enable-gated storage elements.
- One write port with byte enables, two combinational read ports, optional write-to-read bypass, optional hardwired-zero entry 0.
- Adds a sequenced bulk-clear engine that sweeps one entry per cycle, with a busy flag.
- Serves as the general datapath register bank for CPU and accelerator blocks.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; must be ≥2.
- ADDR_W, 5, address width; must satisfy 2^ADDR_W ≥ DEPTH.
- BYPASS, 1, 1 = a same-cycle write is forwarded to read data; 0 = reads return stored contents only.
- ZERO_REG0, 1, 1 = entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- we  in  1  write request.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- wbe  in  WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
- wr_ack  out  1  combinational; high when the current write is accepted.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  WIDTH  read data, port A; combinational.
- raddr_b  in  ADDR_W  read address, port B.
- rdata_b  out  WIDTH  read data, port B; combinational.
- clr_req  in  1  single-cycle pulse that starts a bulk clear.
- busy  out  1  high while a bulk clear is in progress.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - all entries = 0; FSM = IDLE; sweep pointer = 0; busy = 0.
  - Reset has priority over every other input. Release is sampled on the next rising edge.
- Write accept:
  - wr_ack = we & !busy & (waddr < DEPTH) & !(ZERO_REG0 & waddr==0).
  - On the edge, an accepted write updates only the bytes with wbe[i]=1; all other bytes hold.
  - wbe = 0 with wr_ack = 1 is legal and changes no data.
  - Entries with no accepted write hold their value. Disabled entries are not cleared.
- Read:
  - rdata = entry[raddr], zero latency.
  - raddr ≥ DEPTH returns 0.
  - ZERO_REG0=1 and raddr==0 returns 0.
- Bypass (BYPASS=1):
  - Applies when wr_ack=1 and raddr==waddr.
  - rdata = per-byte merge: wdata byte where wbe=1, stored byte otherwise.
  - Both ports bypass independently; two ports reading the same address return identical data.
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clr_req=1 → SWEEP, ptr←0.
  - SWEEP: each edge, entry[ptr]←0 and ptr←ptr+1. At ptr==DEPTH-1 the final clear happens and the FSM returns to IDLE.
  - Sweep length is exactly DEPTH cycles. busy is high for exactly those DEPTH cycles, starting the cycle after clr_req is sampled.
  - clr_req during SWEEP is ignored (no restart, no extension).
  - Writes during SWEEP are refused (wr_ack=0) and dropped; the requester must retry.
  - Reads during SWEEP return current contents: cleared entries read 0, not-yet-cleared entries read old data.
- Simultaneous clr_req and we in IDLE: the write is accepted on that edge, then the sweep clears it.
- Reset mid-sweep: immediate return to IDLE with all entries 0 and busy=0.
- Boundaries:
  - waddr ≥ DEPTH: wr_ack=0, no state change.
  - Pointer never exceeds DEPTH-1.

Test Plan:
- Assert rst=0 mid-cycle after writing 0xDEADBEEF to entry 5 → rdata_a@5 = 0 immediately, busy=0.
- Write 0x11223344 to entry 3 with wbe=4'b1111, then 0xAABBCCDD with wbe=4'b0101 → entry 3 = 0x11BB33DD.
- BYPASS=1: entry 7 holds 0x0; same cycle we=1, waddr=7, wdata=0x12345678, wbe=4'b0011, raddr_a=raddr_b=7 → both rdata = 0x00005678 combinationally, and stored after the edge.
- ZERO_REG0=1: write 0xFFFFFFFF to entry 0 → wr_ack=0, rdata_a@0 = 0. Write to waddr=40 with DEPTH=32 → wr_ack=0, no state change.
- Fill all 32 entries with their index, then pulse clr_req → busy high for exactly 32 cycles.
  - At cycle 10 of the sweep: entries 0-9 read 0, entries 10-31 read old values.
  - A write at cycle 10 gets wr_ack=0.
  - A second clr_req at cycle 12 does not extend the sweep.
  - Afterwards all entries read 0.
- Start a sweep, assert rst=0 at cycle 5 → busy=0 immediately. After release, a write to entry 20 is accepted and reads back.
